// File: rtl/bcd_seq_adder.sv
// Sequential packed-BCD adder/subtractor: one decimal digit per clock,
// least significant digit first, with a three-state IDLE/RUN/DONE controller.
module bcd_seq_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err,
  output logic                  busy,
  output logic                  done
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            sub_q, sub_d, carry_q, carry_d;
  logic            cout_q, cout_d, err_q, err_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [IW-1:0]   idx_q, idx_d;

  logic [3:0]      a_dig_s, b_dig_s, b_eff_s, res_dig_s;
  logic [4:0]      t_s;
  logic            carry_nxt_s;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | (v[4*i +: 4] > 4'd9);
    end
    return bad;
  endfunction

  // Single-digit decimal adder on the digit selected by idx.
  always_comb begin
    a_dig_s     = a_q[{idx_q, 2'b00} +: 4];
    b_dig_s     = b_q[{idx_q, 2'b00} +: 4];
    b_eff_s     = sub_q ? (4'd9 - b_dig_s) : b_dig_s;
    t_s         = {1'b0, a_dig_s} + {1'b0, b_eff_s} + {4'b0000, carry_q};
    carry_nxt_s = (t_s > 5'd9);
    res_dig_s   = carry_nxt_s ? (t_s[3:0] + 4'd6) : t_s[3:0];
  end

  // Controller next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          if (has_bad_digit(a) || has_bad_digit(b)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = res_dig_s;
        carry_d = carry_nxt_s;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(DIGITS - 1)) begin
          cout_d  = carry_nxt_s;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Scoreboard bench for bcd_seq_adder: expected results come from integer
// decimal arithmetic and are checked by an independent done-driven monitor.
module tb_bcd_seq_adder;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] sum;
  logic         cout, err, busy, done;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;

  bcd_seq_adder #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
    .a(a), .b(b), .sum(sum), .cout(cout), .err(err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r;
    longint x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Decimal reference: operands as integers, result by plain arithmetic.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic s, input logic ci, input int c0);
    exp_t   e;
    longint ai, bi, r, m;
    logic   bad;
    ai = 0; bi = 0; m = 1; bad = 1'b0;
    for (int i = D - 1; i >= 0; i--) begin
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) bad = 1'b1;
      ai = ai * 10 + longint'(av[4*i +: 4]);
      bi = bi * 10 + longint'(bv[4*i +: 4]);
      m  = m * 10;
    end
    if (bad) begin
      e.sum = '0; e.cout = 1'b0; e.err = 1'b1; e.cyc = c0 + 1;
    end else begin
      if (!s) begin
        r = ai + bi + longint'(ci);
        e.cout = (r >= m);
        r = r % m;
      end else begin
        e.cout = (ai >= bi);
        r = e.cout ? (ai - bi) : (ai - bi + m);
      end
      e.sum = int2bcd(r);
      e.err = 1'b0;
      e.cyc = c0 + 1 + D;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sum",  64'(sum),  64'(e.sum));
        check("cout", 64'(cout), 64'(e.cout));
        check("err",  64'(err),  64'(e.err));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        last_exp = e;
      end
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: actual=0 required=1");
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic s, input logic ci);
    exp_t e;
    @(negedge clk);
    a = av; b = bv; sub = s; cin = ci; start = 1'b1;
    e = model(av, bv, s, ci, cyc);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(!e.err));
    wait_done();
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  initial begin
    logic [W-1:0] ra, rb;
    int           dn;

    @(negedge clk);
    check("rst_sum",  64'(sum),  64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cout_err", 64'({cout, err}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(16'h1234, 16'h5678, 1'b0, 1'b0);
    issue(16'h9999, 16'h0001, 1'b0, 1'b0);
    issue(16'h9999, 16'h0001, 1'b0, 1'b1);
    issue(16'h0500, 16'h0123, 1'b1, 1'b0);
    issue(16'h0123, 16'h0500, 1'b1, 1'b1);
    issue(16'h12A4, 16'h0001, 1'b0, 1'b0);
    issue(16'h0000, 16'h0000, 1'b1, 1'b0);

    // start and operand changes while busy must not disturb the running op
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; sub = 1'b0; cin = 1'b1; start = 1'b1;
    exp_q.push_back(model(16'h4321, 16'h1111, 1'b0, 1'b1, cyc));
    @(negedge clk);
    start = 1'b0;
    check("busy_run", 64'(busy), 64'd1);
    @(negedge clk);
    a = 16'h9999; b = 16'h9999; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (8) @(negedge clk);

    // reset mid-run: outputs clear asynchronously, no done pulse
    a = 16'h1234; b = 16'h5678; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("busy_before_rst", 64'(busy), 64'd1);
    check("partial_sum", 64'(sum), 64'h0012);
    rst = 1'b1;
    #1;
    check("async_rst_sum",  64'(sum),  64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_flags", 64'({cout, err, done}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    issue(16'h0999, 16'h0001, 1'b0, 1'b0);

    // start held high: back-to-back operations, one IDLE cycle apart
    @(negedge clk);
    a = 16'h2468; b = 16'h1357; sub = 1'b0; cin = 1'b1; start = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(model(a, b, sub, cin, cyc + k * (D + 2)));
    dn = 0;
    for (int n = 0; n < 60 && dn < 3; n++) begin
      @(negedge clk);
      if (done) dn++;
    end
    start = 1'b0;
    check("held_start_dones", 64'(dn), 64'd3);
    @(negedge clk);

    for (int k = 0; k < 150; k++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      if ($urandom_range(0, 9) == 0) ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 9) == 0) rb[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check("sum_hold", 64'(sum), 64'(last_exp.sum));
    check("cout_hold", 64'(cout), 64'(last_exp.cout));
    check("pending_expectations", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
